// File: rtl/debug_tx_dumper.sv
// Transmit-side dump sequencer of the UART debugger: streams PC, all registers and
// all data-memory words to the TX FIFO as N-bit bytes, MSB byte first.
module debug_tx_dumper #(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 5,
  parameter int unsigned PC_SZ   = 32,
  parameter int unsigned DATA_SZ = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [PC_SZ-1:0]   i_pc,
  input  logic [DATA_SZ-1:0] i_register_data,
  input  logic [DATA_SZ-1:0] i_memory_data,
  input  logic               i_tx_full,
  output logic [W-1:0]       o_addr,
  output logic [N-1:0]       o_tx_data,
  output logic               o_tx_wr,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned WORDS  = 1 << W;
  localparam int unsigned LAST_K = 2 * WORDS;
  localparam int unsigned KW     = $clog2(LAST_K + 1);
  localparam int unsigned BYTES  = DATA_SZ / N;
  localparam int unsigned BCW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [BCW-1:0]     cnt_q, cnt_d;
  logic [DATA_SZ-1:0] shift_q, shift_d;
  logic [W-1:0]       addr_q, addr_d;
  logic [N-1:0]       last_q, last_d;

  logic [N-1:0] cur_byte;
  logic         last_byte;
  logic         last_word;

  assign cur_byte  = shift_q[DATA_SZ-1 -: N];
  assign last_byte = (cnt_q == BCW'(BYTES - 1));
  assign last_word = (k_q == KW'(LAST_K));
  assign o_addr    = addr_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = FETCH1;
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = SEND;
      SEND:    if (!i_tx_full && last_byte) state_d = last_word ? DONE : FETCH1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx_wr   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_tx_data = last_q;
    unique case (state_q)
      IDLE:   ;
      FETCH1: o_busy = 1'b1;
      FETCH2: o_busy = 1'b1;
      SEND: begin
        o_busy = 1'b1;
        if (!i_tx_full) begin
          o_tx_wr   = 1'b1;
          o_tx_data = cur_byte;
        end
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Word index, byte counter, shift register, debug address and held TX byte.
  always_comb begin
    k_d     = k_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          k_d    = '0;
          cnt_d  = '0;
          addr_d = '0;
        end
      end
      FETCH2: begin
        cnt_d = '0;
        if (k_q == '0)                 shift_d = DATA_SZ'(i_pc);
        else if (k_q <= KW'(WORDS))    shift_d = i_register_data;
        else                           shift_d = i_memory_data;
      end
      SEND: begin
        if (!i_tx_full) begin
          last_d  = cur_byte;
          shift_d = shift_q << N;
          if (last_byte) begin
            cnt_d = '0;
            // Address of word k+1 is (k+1)-1 modulo 2^W.
            if (!last_word) begin
              k_d    = k_q + KW'(1);
              addr_d = W'(k_q);
            end
          end else begin
            cnt_d = cnt_q + BCW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      k_q     <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

endmodule
